// File: rtl/sram_arbiter_if.sv
// Shared bus between the inst/data masters, the arbiter and the memory slave.
// Modport master is the arbiter's view; slave is the surrounding cores and memory.
interface sram_arbiter_if;
  logic        inst_en;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_ok;
  logic        data_en;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_ok;
  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    input  inst_en, inst_addr,
    input  data_en, data_wen, data_addr, data_wdata,
    input  mem_ack, mem_rdata,
    output inst_rdata, inst_ok,
    output data_rdata, data_ok,
    output mem_req, mem_wr, mem_wstrb,
    output mem_addr, mem_wdata
  );

  modport slave (
    output inst_en, inst_addr,
    output data_en, data_wen, data_addr, data_wdata,
    output mem_ack, mem_rdata,
    input  inst_rdata, inst_ok,
    input  data_rdata, data_ok,
    input  mem_req, mem_wr, mem_wstrb,
    input  mem_addr, mem_wdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin inst/data arbiter onto one registered req/ack memory port.
// Optional watchdog enabled by defining SRAM_ARB_TIMEOUT_EN.
module sram_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic           clk,
  input  logic           reset,
  sram_arbiter_if.master bus,
  output logic           arb_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_t;

  if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 255) begin : g_bad_tmo
    $error("TIMEOUT_CYCLES must be 1..255");
  end

  state_t      state_q, state_d;
  logic        gnt_d_q, gnt_d_d;
  logic        last_d_q, last_d_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_wr_q, mem_wr_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        inst_ok_q, inst_ok_d;
  logic        data_ok_q, data_ok_d;
  logic [31:0] inst_rdata_q, inst_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;
  logic        pick_d;
  logic        tmo;

`ifdef SRAM_ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;

  // ack on the deadline cycle wins over the watchdog
  assign tmo = (state_q == S_BUSY) && !bus.mem_ack
             && (cnt_q == 8'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = '0;
    err_d = err_q | tmo;
    if (state_q == S_BUSY) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign arb_err = err_q;
`else
  assign tmo     = 1'b0;
  assign arb_err = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    gnt_d_d      = gnt_d_q;
    last_d_d     = last_d_q;
    mem_req_d    = mem_req_q;
    mem_wr_d     = mem_wr_q;
    mem_wstrb_d  = mem_wstrb_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    inst_ok_d    = 1'b0;
    data_ok_d    = 1'b0;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    pick_d       = bus.data_en && (!bus.inst_en || !last_d_q);
    unique case (state_q)
      S_IDLE: begin
        if (bus.inst_en || bus.data_en) begin
          gnt_d_d   = pick_d;
          mem_req_d = 1'b1;
          state_d   = S_BUSY;
          if (pick_d) begin
            mem_wr_d    = |bus.data_wen;
            mem_wstrb_d = bus.data_wen;
            mem_addr_d  = bus.data_addr;
            mem_wdata_d = bus.data_wdata;
          end else begin
            mem_wr_d    = 1'b0;
            mem_wstrb_d = 4'b0000;
            mem_addr_d  = bus.inst_addr;
            mem_wdata_d = '0;
          end
        end
      end
      S_BUSY: begin
        if (bus.mem_ack || tmo) begin
          mem_req_d = 1'b0;
          last_d_d  = gnt_d_q;
          state_d   = S_RESP;
          if (gnt_d_q) begin
            data_ok_d = 1'b1;
            if (!bus.mem_ack)  data_rdata_d = '0;
            else if (!mem_wr_q) data_rdata_d = bus.mem_rdata;
          end else begin
            inst_ok_d    = 1'b1;
            inst_rdata_d = bus.mem_ack ? bus.mem_rdata : '0;
          end
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      gnt_d_q      <= 1'b0;
      last_d_q     <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_wstrb_q  <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      inst_ok_q    <= 1'b0;
      data_ok_q    <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      gnt_d_q      <= gnt_d_d;
      last_d_q     <= last_d_d;
      mem_req_q    <= mem_req_d;
      mem_wr_q     <= mem_wr_d;
      mem_wstrb_q  <= mem_wstrb_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      inst_ok_q    <= inst_ok_d;
      data_ok_q    <= data_ok_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_wr     = mem_wr_q;
  assign bus.mem_wstrb  = mem_wstrb_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.inst_ok    = inst_ok_q;
  assign bus.data_ok    = data_ok_q;
  assign bus.inst_rdata = inst_rdata_q;
  assign bus.data_rdata = data_rdata_q;

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-master, one-slave memory arbiter sitting directly downstream of the CPU core's instruction and data SRAM ports, after kseg0/kseg1 address mapping. It serialises instruction fetches and data accesses onto a single shared memory port with a req/ack handshake, registers the selected request, and returns read data with a one-cycle `ok` pulse per completed access. Round-robin grant prevents starvation of either side.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: watchdog limit in cycles of `mem_req` high without `mem_ack`; used only when `SRAM_ARB_TIMEOUT_EN` is defined; legal 1..255.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `inst_en`  in  1  instruction read request; held until `inst_ok`.
- `inst_addr`  in  32  physical fetch address.
- `inst_rdata`  out  32  fetch data; valid when `inst_ok`=1.
- `inst_ok`  out  1  one-cycle completion pulse for instruction side.
- `data_en`  in  1  data request; held until `data_ok`.
- `data_wen`  in  4  byte write strobes; 4'b0000 = read.
- `data_addr`  in  32  physical data address.
- `data_wdata`  in  32  store data.
- `data_rdata`  out  32  load data; valid when `data_ok`=1.
- `data_ok`  out  1  one-cycle completion pulse for data side.
- `mem_req`  out  1  downstream request, held until `mem_ack`.
- `mem_wr`  out  1  1 = write.
- `mem_wstrb`  out  4  byte strobes (0 for reads).
- `mem_addr`  out  32  downstream address.
- `mem_wdata`  out  32  downstream write data.
- `mem_ack`  in  1  slave completion; `mem_rdata` valid same cycle.
- `mem_rdata`  in  32  slave read data.
- `arb_err`  out  1  sticky timeout flag (timeout build only, else tied 0).

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: if neither `inst_en` nor `data_en`, stay. Else pick winner, latch its addr/wen/wdata into `mem_*` registers, set `mem_req`=1, go BUSY.
- Grant: only one requesting -> that one. Both -> side not granted last time (`last_grant` flag). Reset value of `last_grant` = inst, so data wins first tie.
- BUSY: `mem_*` outputs stable. On `mem_ack`=1: capture `mem_rdata` into winner's rdata register (reads only; writes leave rdata unchanged), drop `mem_req`, update `last_grant`, go RESP.
- RESP: assert winner's `*_ok` for exactly this cycle; go IDLE. Requests are not sampled in RESP.
- `mem_wr` = |`data_wen` for data grants, 0 for inst grants; `mem_wstrb` = `data_wen` or 4'b0000.
- Master must drop or change its request in the cycle its `ok` is high; arbiter samples again in the following IDLE cycle.
- Non-granted master's request is ignored until the arbiter returns to IDLE; its inputs are not latched.

## Timing
- Reset values: state IDLE, `mem_req`/`mem_wr`=0, `mem_wstrb`=0, `mem_addr`/`mem_wdata`=0, `inst_ok`/`data_ok`=0, `inst_rdata`/`data_rdata`=0, `arb_err`=0, `last_grant`=inst.
- Latency: request seen in IDLE cycle T -> `mem_req` high from T+1 -> ack at T+1+W (W>=0 wait cycles) -> `ok` at T+2+W. Minimum 2 cycles, throughput one access per 3 cycles.
- `mem_ack` outside BUSY is ignored.
- Reset mid-transaction (BUSY or RESP): next edge forces all reset values; pending `ok` is lost; `mem_req` low after that edge.
- Both requests arriving the same cycle as an `ok`: not sampled until IDLE.

## Configuration
- `SRAM_ARB_TIMEOUT_EN` defined: 8-bit counter clears on entering BUSY, increments each BUSY cycle without `mem_ack`; when it reaches `TIMEOUT_CYCLES`, drop `mem_req`, return rdata 32'h0000_0000 to the winner, go RESP, set `arb_err`=1 (sticky until `reset`). Ack in the same cycle as timeout wins (normal completion).
- Not defined: no counter, BUSY waits indefinitely, `arb_err` tied 0.

## Test plan
- Inst read only, addr 0x0000_1000, slave acks 0 wait with 0x2402_0001 -> `mem_req` 1 cycle, `inst_ok` at T+2, `inst_rdata`=0x2402_0001, `mem_wr`=0.
- Data write addr 0x0000_2004, wen 4'b0011, wdata 0xDEAD_BEEF, 3 wait cycles -> `mem_wr`=1, `mem_wstrb`=4'b0011 stable 4 cycles, `data_ok` at T+5, `data_rdata` unchanged.
- Both requesting continuously from reset -> grants alternate data, inst, data, inst; each `ok` 3 cycles apart.
- `mem_ack` pulsed while IDLE -> no state change, no `ok`.
- `reset` asserted in BUSY with 5-cycle-delayed ack -> `mem_req` 0 next cycle, no `ok`, ack later ignored.
- Timeout build, `TIMEOUT_CYCLES`=4, slave never acks -> `mem_req` drops after 4 BUSY cycles, `inst_ok`=1 with rdata 0, `arb_err`=1 and stays 1 until reset.
